// File: rtl/ram_access_ctrl_if.sv
// Host request/response bundle for ram_access_ctrl.
// The host drives requests through the master modport; the controller uses the slave modport.
interface ram_access_ctrl_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [2:0]        req_len;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              addr_err;
  logic              verify_err;

  modport master (
    output req_valid, req_wr, req_addr, req_data, req_len,
    input  req_ready, resp_valid, resp_data, addr_err, verify_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_data, req_len,
    output req_ready, resp_valid, resp_data, addr_err, verify_err
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Host-side controller for the 4-entry negedge scratch RAM: preload, single writes, wrapping read bursts.
// Optional write read-back check is enabled by defining RAM_CTRL_VERIFY_EN.
module ram_access_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_access_ctrl_if.slave  host,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_set_mem,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   ADDR_LIM  = (ADDR_W + 1)'(DEPTH);

`ifdef RAM_CTRL_VERIFY_EN
  typedef enum logic [2:0] {INIT, PRELOAD, IDLE, WRITE, READ, VREAD, VCHECK} state_e;
`else
  typedef enum logic [2:0] {INIT, PRELOAD, IDLE, WRITE, READ} state_e;
`endif

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              addr_err_q, addr_err_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wr_q, ram_wr_d;
  logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;
  logic              ram_set_mem_q, ram_set_mem_d;
  logic [2:0]        cnt_q, cnt_d;
`ifdef RAM_CTRL_VERIFY_EN
  logic              verify_err_q, verify_err_d;
`endif

  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = 1'b0;
    resp_data_d   = resp_data_q;
    addr_err_d    = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wr_d      = 1'b0;
    ram_data_in_d = ram_data_in_q;
    ram_set_mem_d = 1'b1;
    cnt_d         = cnt_q;
`ifdef RAM_CTRL_VERIFY_EN
    verify_err_d  = verify_err_q;
`endif
    unique case (state_q)
      INIT: begin
        ram_set_mem_d = 1'b0;
        state_d       = PRELOAD;
      end
      PRELOAD: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      IDLE: begin
        if (host.req_valid && req_ready_q) begin
          // Out-of-range requests are consumed without touching the RAM port.
          if ({1'b0, host.req_addr} >= ADDR_LIM) begin
            addr_err_d = 1'b1;
          end else if (host.req_wr) begin
            req_ready_d   = 1'b0;
            ram_wr_d      = 1'b1;
            ram_addr_d    = host.req_addr;
            ram_data_in_d = host.req_data;
            state_d       = WRITE;
          end else begin
            req_ready_d = 1'b0;
            ram_addr_d  = host.req_addr;
            cnt_d       = host.req_len;
            state_d     = READ;
          end
        end
      end
      WRITE: begin
`ifdef RAM_CTRL_VERIFY_EN
        state_d = VREAD;
`else
        req_ready_d = 1'b1;
        state_d     = IDLE;
`endif
      end
      READ: begin
        // ram_data_out was refreshed on the negedge for the address presented this cycle.
        resp_data_d  = ram_data_out;
        resp_valid_d = 1'b1;
        ram_addr_d   = (ram_addr_q == LAST_ADDR) ? '0 : ram_addr_q + 1'b1;
        if (cnt_q == 3'd0) begin
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
`ifdef RAM_CTRL_VERIFY_EN
      VREAD: begin
        if (ram_data_out != ram_data_in_q) verify_err_d = 1'b1;
        state_d = VCHECK;
      end
      VCHECK: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
`endif
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= INIT;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      addr_err_q    <= 1'b0;
      ram_addr_q    <= '0;
      ram_wr_q      <= 1'b0;
      ram_data_in_q <= '0;
      ram_set_mem_q <= 1'b1;
      cnt_q         <= '0;
`ifdef RAM_CTRL_VERIFY_EN
      verify_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      addr_err_q    <= addr_err_d;
      ram_addr_q    <= ram_addr_d;
      ram_wr_q      <= ram_wr_d;
      ram_data_in_q <= ram_data_in_d;
      ram_set_mem_q <= ram_set_mem_d;
      cnt_q         <= cnt_d;
`ifdef RAM_CTRL_VERIFY_EN
      verify_err_q  <= verify_err_d;
`endif
    end
  end

  assign host.req_ready  = req_ready_q;
  assign host.resp_valid = resp_valid_q;
  assign host.resp_data  = resp_data_q;
  assign host.addr_err   = addr_err_q;
`ifdef RAM_CTRL_VERIFY_EN
  assign host.verify_err = verify_err_q;
`else
  assign host.verify_err = 1'b0;
`endif
  assign ram_addr    = ram_addr_q;
  assign ram_wr      = ram_wr_q;
  assign ram_data_in = ram_data_in_q;
  assign ram_set_mem = ram_set_mem_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed + randomized bench for ram_access_ctrl with a negedge RAM model and an array-based reference.
module tb_ram_access_ctrl;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) host ();
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr, ram_set_mem;
  logic [DATA_W-1:0] ram_data_in, ram_data_out;

  ram_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .host(host),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_data_in(ram_data_in),
    .ram_set_mem(ram_set_mem), .ram_data_out(ram_data_out)
  );

  // RAM: negedge sampled, read-first, optional bit-0 stuck-at-0 on writes
  logic [DATA_W-1:0] mem [DEPTH];
  bit stuck = 1'b0;
  always @(negedge clk) begin
    if (!ram_set_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i + 2);
    end else if (ram_wr) begin
      mem[ram_addr[1:0]] <= stuck ? (ram_data_in & 4'hE) : ram_data_in;
    end
    ram_data_out <= mem[ram_addr[1:0]];
  end

  // Reference model
  int ref_mem [DEPTH];
  int exp_addr;
  bit exp_verr;
  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = i + 2;
    exp_addr = 0;
    exp_verr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    host.req_valid = 1'b0;
    tick();
    tick();
    check("rst_req_ready", host.req_ready, 0);
    check("rst_resp_valid", host.resp_valid, 0);
    check("rst_resp_data", host.resp_data, 0);
    check("rst_addr_err", host.addr_err, 0);
    check("rst_verify_err", host.verify_err, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wr", ram_wr, 0);
    check("rst_ram_data_in", ram_data_in, 0);
    check("rst_set_mem", ram_set_mem, 1);
    rst_n = 1'b1;
    tick();
    check("init_set_mem_low", ram_set_mem, 0);
    check("init_ready_low", host.req_ready, 0);
    tick();
    check("preload_set_mem_high", ram_set_mem, 1);
    check("preload_ready_high", host.req_ready, 1);
    preload_model();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && host.req_ready !== 1'b1; i++) tick();
    check("ready_wait", host.req_ready, 1);
  endtask

  task automatic issue(input bit wr, input int a, input int d, input int len);
    host.req_valid = 1'b1;
    host.req_wr    = wr;
    host.req_addr  = ADDR_W'(a);
    host.req_data  = DATA_W'(d);
    host.req_len   = 3'(len);
    tick();
    // Fields scrambled after accept; they must be ignored while busy
    host.req_valid = 1'b0;
    host.req_wr    = 1'($urandom);
    host.req_addr  = ADDR_W'($urandom);
    host.req_data  = DATA_W'($urandom);
    host.req_len   = 3'($urandom);
  endtask

  task automatic do_write(input int a, input int d);
    wait_ready();
    issue(1'b1, a, d, $urandom_range(0, 7));
    check("wr_ram_wr_high", ram_wr, 1);
    check("wr_ram_addr", ram_addr, a);
    check("wr_ram_data_in", ram_data_in, d);
    check("wr_ready_low", host.req_ready, 0);
    check("wr_no_resp", host.resp_valid, 0);
    ref_mem[a] = stuck ? (d & 'hE) : d;
    exp_addr = a;
    tick();
    check("wr_ram_wr_low", ram_wr, 0);
    check("wr_no_resp2", host.resp_valid, 0);
`ifdef RAM_CTRL_VERIFY_EN
    check("wr_vread_ready_low", host.req_ready, 0);
    tick();
    check("wr_vcheck_ready_low", host.req_ready, 0);
    check("wr_vcheck_ram_wr", ram_wr, 0);
    if (ref_mem[a] != d) exp_verr = 1'b1;
    tick();
    check("wr_verify_ready", host.req_ready, 1);
    check("wr_verify_addr_held", ram_addr, a);
`else
    check("wr_ready_back", host.req_ready, 1);
`endif
    check("wr_verify_err", host.verify_err, exp_verr);
  endtask

  task automatic do_read(input int a, input int len);
    wait_ready();
    issue(1'b0, a, $urandom_range(0, 15), len);
    check("rd_ready_low", host.req_ready, 0);
    check("rd_no_resp_e0", host.resp_valid, 0);
    check("rd_ram_addr", ram_addr, a);
    for (int i = 0; i <= len; i++) begin
      tick();
      check("rd_beat_valid", host.resp_valid, 1);
      check("rd_beat_data", host.resp_data, ref_mem[(a + i) % DEPTH]);
      check("rd_beat_ready", host.req_ready, (i == len) ? 1 : 0);
    end
    exp_addr = (a + len + 1) % DEPTH;
    check("rd_end_addr", ram_addr, exp_addr);
    tick();
    check("rd_resp_drop", host.resp_valid, 0);
  endtask

  task automatic do_bad(input int a, input bit wr);
    wait_ready();
    issue(wr, a, $urandom_range(0, 15), $urandom_range(0, 7));
    check("bad_addr_err", host.addr_err, 1);
    check("bad_ready_stays", host.req_ready, 1);
    check("bad_no_resp", host.resp_valid, 0);
    check("bad_no_wr", ram_wr, 0);
    check("bad_addr_held", ram_addr, exp_addr);
    tick();
    check("bad_addr_err_pulse", host.addr_err, 0);
    check("bad_no_resp2", host.resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    host.req_valid = 1'b0;
    host.req_wr    = 1'b0;
    host.req_addr  = '0;
    host.req_data  = '0;
    host.req_len   = '0;

    do_reset();
    tick();
    check("set_mem_single_pulse", ram_set_mem, 1);

    for (int a = 0; a < DEPTH; a++) do_read(a, 0);
    do_read(2, 3);
    do_write(1, 'hA);
    do_read(1, 0);
    do_bad(6, 1'b0);

    // Reset in the middle of a len 5 burst
    wait_ready();
    issue(1'b0, 0, 0, 5);
    tick();
    check("mid_beat1", host.resp_data, ref_mem[0]);
    tick();
    check("mid_beat2", host.resp_data, ref_mem[1]);
    rst_n = 1'b0;
    tick();
    check("mid_rst_no_resp", host.resp_valid, 0);
    check("mid_rst_ready", host.req_ready, 0);
    do_reset();
    do_read(1, 0);

    for (int n = 0; n < 30; n++) begin
      int a;
      a = $urandom_range(0, 7);
      if (a >= DEPTH) do_bad(a, 1'($urandom));
      else if ($urandom_range(0, 1) == 0) do_write(a, $urandom_range(0, 15));
      else do_read(a, $urandom_range(0, 7));
    end

    do_write(3, 'h5);
    check("clean_verify_err", host.verify_err, 0);
    stuck = 1'b1;
    do_write(2, 'h5);
    do_read(2, 0);
    do_read($urandom_range(0, 3), $urandom_range(0, 7));
    check("stuck_verify_sticky", host.verify_err, exp_verr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Host-side controller that drives the single-port 4-entry scratch RAM (the addr/wr/data_in/data_out/set_mem port with negedge-sampled memory). It turns valid/ready host requests into correctly timed RAM pin activity, preloads the RAM after reset, and returns read data as response pulses, including wrapping read bursts. It sits between the host command logic and the RAM instance and is the only block that drives the RAM port.

## Interface
- DATA_W, 4, data width; equals RAM word width
- ADDR_W, 3, address width; equals RAM addr width
- DEPTH, 4, implemented RAM entries; burst wrap point and legal address limit
- clk  in  1  clock; all state on posedge; RAM samples on negedge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  host request present
- req_ready  out  1  controller can accept a request
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  start address
- req_data  in  DATA_W  write data
- req_len  in  3  extra read beats (0..7); ignored for writes
- resp_valid  out  1  one-cycle pulse per read beat; no backpressure
- resp_data  out  DATA_W  read data, valid with resp_valid
- addr_err  out  1  one-cycle pulse: request rejected, req_addr >= DEPTH
- verify_err  out  1  sticky write-verify mismatch (see Configuration)
- ram_addr  out  ADDR_W  to RAM addr
- ram_wr  out  1  to RAM wr
- ram_data_in  out  DATA_W  to RAM data_in
- ram_set_mem  out  1  to RAM set_mem; active-low preload strobe
- ram_data_out  in  DATA_W  from RAM data_out

## Operation
- All outputs registered. Reset values: req_ready 0, resp_valid 0, resp_data 0, addr_err 0, verify_err 0, ram_addr 0, ram_wr 0, ram_data_in 0, ram_set_mem 1; state INIT.
- States: INIT, PRELOAD, IDLE, WRITE, READ, VREAD, VCHECK.
- INIT -> PRELOAD: ram_set_mem <= 0. PRELOAD -> IDLE: ram_set_mem <= 1, req_ready <= 1. Exactly one cycle of ram_set_mem low per reset; RAM reloads 2,3,4,5 into 0..3.
- IDLE: req_ready = 1. Accept on posedge with req_valid & req_ready; req_ready <= 0 on the same edge, request fields latched.
- Accept with req_addr >= DEPTH: addr_err pulses, no RAM access, stay IDLE, req_ready stays 1.
- Write accept -> WRITE: ram_wr <= 1, ram_addr <= req_addr, ram_data_in <= req_data. Next edge: ram_wr <= 0; -> IDLE, req_ready <= 1 (or -> VREAD if verify compiled in).
- Read accept -> READ: ram_wr <= 0, ram_addr <= req_addr, beat counter <= req_len. Each READ edge: resp_data <= ram_data_out, resp_valid <= 1, ram_addr <= (ram_addr == DEPTH-1) ? 0 : ram_addr+1, counter decrements; on the edge where counter is 0 -> IDLE, req_ready <= 1.
- resp_valid is low in every cycle without a new beat.
- req_* ignored while req_ready = 0; no queueing.
- Reset mid-operation: on the reset edge all outputs take reset values, any burst is abandoned with no further resp_valid, and the INIT/PRELOAD sequence repeats; RAM contents return to preload values.

## Timing
- Write: accept edge E0; ram_wr high E0..E1 (RAM writes on the negedge between); req_ready high after E1. Back-to-back writes: one every 2 cycles.
- Read: accept edge E0; first resp_valid visible after E1; beats on consecutive cycles; N = req_len+1 beats; req_ready high after edge E(N).
- Read latency is 2 edges from accept to data visible. ram_data_out is sampled only on posedges, one half-cycle after the RAM negedge update.
- After reset release, req_ready rises after the 2nd posedge with rst_n high.

## Configuration
- RAM_CTRL_VERIFY_EN defined: WRITE -> VREAD, with ram_addr held and ram_wr 0 for one cycle. VREAD -> VCHECK compares ram_data_out to the latched write data; a mismatch sets verify_err, which stays set until reset. VCHECK -> IDLE, req_ready <= 1. Write-to-ready is 3 cycles.
- Not defined: no VREAD/VCHECK states; verify_err is tied to 0; write-to-ready is 1 cycle after the WRITE cycle.

## Test plan
- Reset release, idle -> ram_set_mem low for exactly 1 cycle; req_ready high 2 edges after release; then read addr 0..3 len 0 each -> resp_data 2, 3, 4, 5.
- Read burst addr 2, len 3 -> 4 consecutive resp_valid beats with data 4, 5, 2, 3 (wrap at DEPTH); req_ready low throughout and high after the last beat.
- Write addr 1 data 0xA, then read addr 1 -> resp_data 0xA; ram_wr high for exactly 1 cycle; no resp_valid for the write.
- Read addr 6 -> addr_err pulse for 1 cycle; no ram_addr change; no resp_valid; req_ready stays 1.
- rst_n low during the 2nd beat of a len 5 burst -> no further resp_valid; preload repeats; read addr 1 -> 3 even after a prior write of 0xA.
- With RAM_CTRL_VERIFY_EN, RAM model forcing bit 0 stuck at 0, write 0x5 -> verify_err set and remains set; with clean RAM, write 0x5 -> verify_err stays 0.
